// File: rtl/r2z_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : r2z_conv_arbiter
// Purpose  : Round-robin shared float-to-int16 (toward zero) converter with a
//            two-stage valid/ready pipeline and a completed-conversion counter.
//            Optional macro R2Z_SAT_EN saturates out-of-range results.
// Revision : 1.0 - initial release
// ============================================================================
module r2z_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_data,
    output logic [ID_W-1:0]         out_id,
    output logic [15:0]             conv_count
);

    localparam logic [ID_W-1:0] c_rr_init = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    r_rr_last;
    logic               r_s1_valid;
    logic [31:0]        r_s1_data;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_out_valid;
    logic [15:0]        r_out_data;
    logic [ID_W-1:0]    r_out_id;
    logic [15:0]        r_conv_count;

    logic [NUM_REQ-1:0] w_hi_mask;
    logic [NUM_REQ-1:0] w_hi_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic [31:0]        w_sel_data;
    logic               w_any;
    logic               w_adv_out;
    logic               w_s1_free;
    logic               w_xfer;

    logic [7:0]         w_exp;
    logic [23:0]        w_man;
    logic [4:0]         w_shamt;
    logic [15:0]        w_mag;
    logic [15:0]        w_conv;

    // Requesters strictly after the last winner take priority over the wrap-around set.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hi_mask
            assign w_hi_mask[gi] = (ID_W'(gi) > r_rr_last);
        end
    endgenerate

    always_comb begin
        w_hi_req   = req_valid & w_hi_mask;
        w_any      = |req_valid;
        w_grant_id = '0;
        w_sel_data = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) w_grant_id = ID_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_hi_req[i]) w_grant_id = ID_W'(i);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) w_sel_data = req_data[32*i +: 32];
        end
    end

    assign w_grant   = w_any ? (NUM_REQ'(1) << w_grant_id) : '0;
    assign w_adv_out = ~r_out_valid | out_ready;
    assign w_s1_free = ~r_s1_valid | w_adv_out;
    assign req_ready = w_grant & {NUM_REQ{w_s1_free & ~rst}};
    assign w_xfer    = w_any & w_s1_free & ~rst;

    // Converter: keep the top e+1 bits of the implicit-one mantissa.
    always_comb begin
        w_exp   = r_s1_data[30:23] - 8'd127;
        w_man   = {1'b1, r_s1_data[22:0]};
        w_shamt = 5'd23 - w_exp[4:0];
        if (w_exp[7]) begin
            w_mag = 16'h0000;
        end else if (w_exp < 8'd15) begin
            w_mag = 16'(w_man >> w_shamt);
        end else begin
            w_mag = w_man[23:8];
        end
        w_conv = r_s1_data[31] ? (~w_mag + 16'd1) : w_mag;
`ifdef R2Z_SAT_EN
        if (!w_exp[7] && (w_exp >= 8'd15)) begin
            w_conv = r_s1_data[31] ? 16'h8000 : 16'h7FFF;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last  <= c_rr_init;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_id    <= '0;
        end else begin
            r_s1_valid <= w_xfer | (r_s1_valid & ~w_adv_out);
            if (w_xfer) begin
                r_rr_last <= w_grant_id;
                r_s1_data <= w_sel_data;
                r_s1_id   <= w_grant_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_id     <= '0;
            r_conv_count <= '0;
        end else begin
            if (w_adv_out) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_conv;
                    r_out_id   <= r_s1_id;
                end
            end
            if (r_out_valid & out_ready) begin
                r_conv_count <= r_conv_count + 16'd1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_id     = r_out_id;
    assign conv_count = r_conv_count;

endmodule
`default_nettype wire
